// File: rtl/traffic_pkg.sv
// ============================================================================
// Module   : traffic_pkg
// Purpose  : Shared types and per-state lamp decode for the traffic controller
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

    typedef enum logic [7:0] {
        ST_RST   = 8'b0000_0001,
        ST_NS_G  = 8'b0000_0010,
        ST_NS_Y  = 8'b0000_0100,
        ST_AR1   = 8'b0000_1000,
        ST_EW_G  = 8'b0001_0000,
        ST_EW_Y  = 8'b0010_0000,
        ST_AR2   = 8'b0100_0000,
        ST_FLASH = 8'b1000_0000
    } state_t;

    typedef struct packed {
        logic g;
        logic y;
        logic r;
    } lamp_t;

    localparam lamp_t LAMP_OFF    = 3'b000;
    localparam lamp_t LAMP_RED    = 3'b001;
    localparam lamp_t LAMP_YELLOW = 3'b010;
    localparam lamp_t LAMP_GREEN  = 3'b100;

    // lit selects the on/off half of the night flash pattern
    function automatic lamp_t ns_lamp(input state_t s, input logic lit);
        case (s)
            ST_NS_G:  return LAMP_GREEN;
            ST_NS_Y:  return LAMP_YELLOW;
            ST_FLASH: return lit ? LAMP_YELLOW : LAMP_OFF;
            default:  return LAMP_RED;
        endcase
    endfunction

    function automatic lamp_t ew_lamp(input state_t s, input logic lit);
        case (s)
            ST_EW_G:  return LAMP_GREEN;
            ST_EW_Y:  return LAMP_YELLOW;
            ST_FLASH: return lit ? LAMP_RED : LAMP_OFF;
            default:  return LAMP_RED;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_timer.sv
// ============================================================================
// Module   : traffic_timer
// Purpose  : Loadable down-counter that parks at zero; shared phase timer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/traffic_ctrl_param.sv
// ============================================================================
// Module   : traffic_ctrl_param
// Purpose  : Parametrised NS/EW traffic-light controller with EW sensor
//            request and night flash mode; registered Moore lamp outputs
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_ctrl_param
    import traffic_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int NS_GREEN   = 64,
    parameter int EW_GREEN   = 32,
    parameter int YELLOW     = 4,
    parameter int ALLRED     = 2,
    parameter int FLASH_HALF = 16
) (
    input  logic clk,
    input  logic rst_,
    input  logic ew_sensor,
    input  logic flash_en,
    output logic ns_green,
    output logic ns_yellow,
    output logic ns_red,
    output logic ew_green,
    output logic ew_yellow,
    output logic ew_red,
    output logic flashing
);

    state_t           r_state;
    state_t           w_next;
    state_t           w_to_ew;
    state_t           w_to_ns;
    logic             r_started;
    logic             r_ew_req;
    logic             r_lit;
    logic             w_lit_next;
    logic             w_zero;
    logic             w_load;
    logic             w_flash_wrap;
    logic [CNT_W-1:0] w_load_val;
    lamp_t            r_ns;
    lamp_t            r_ew;
    logic             r_flashing;

    // flash_en is only honoured where both roads are already red
    assign w_to_ew = flash_en ? ST_FLASH : ST_EW_G;
    assign w_to_ns = flash_en ? ST_FLASH : ST_NS_G;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RST:   if (r_started) w_next = ST_NS_G;
            ST_NS_G:  if (w_zero && (r_ew_req || flash_en)) w_next = ST_NS_Y;
            ST_NS_Y:  if (w_zero) w_next = (ALLRED == 0) ? w_to_ew : ST_AR1;
            ST_AR1:   if (w_zero) w_next = w_to_ew;
            ST_EW_G:  if (w_zero) w_next = ST_EW_Y;
            ST_EW_Y:  if (w_zero) w_next = (ALLRED == 0) ? w_to_ns : ST_AR2;
            ST_AR2:   if (w_zero) w_next = w_to_ns;
            ST_FLASH: if (!flash_en) w_next = (ALLRED == 0) ? ST_NS_G : ST_AR2;
            default:  w_next = ST_RST;
        endcase
    end

    always_comb begin
        w_load_val = '0;
        case (w_next)
            ST_NS_G:        w_load_val = CNT_W'(NS_GREEN - 1);
            ST_NS_Y,
            ST_EW_Y:        w_load_val = CNT_W'(YELLOW - 1);
            ST_EW_G:        w_load_val = CNT_W'(EW_GREEN - 1);
            ST_AR1,
            ST_AR2:         w_load_val = (ALLRED > 0) ? CNT_W'(ALLRED - 1) : '0;
            ST_FLASH:       w_load_val = CNT_W'(FLASH_HALF - 1);
            default:        w_load_val = '0;
        endcase
    end

    // FLASH reuses the phase timer as its half-period counter
    assign w_flash_wrap = (r_state == ST_FLASH) && (w_next == ST_FLASH) && w_zero;
    assign w_load       = (w_next != r_state) || w_flash_wrap;

    always_comb begin
        w_lit_next = 1'b1;
        if (r_state == ST_FLASH) begin
            w_lit_next = w_flash_wrap ? ~r_lit : r_lit;
        end
    end

    traffic_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_     (rst_),
        .load     (w_load),
        .load_val (w_load_val),
        .zero     (w_zero)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state    <= ST_RST;
            r_started  <= 1'b0;
            r_ew_req   <= 1'b0;
            r_lit      <= 1'b1;
            r_ns       <= LAMP_RED;
            r_ew       <= LAMP_RED;
            r_flashing <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_started  <= 1'b1;
            r_lit      <= w_lit_next;
            r_ns       <= ns_lamp(w_next, w_lit_next);
            r_ew       <= ew_lamp(w_next, w_lit_next);
            r_flashing <= (w_next == ST_FLASH);
            if ((w_next == ST_EW_G) && (r_state != ST_EW_G)) begin
                r_ew_req <= 1'b0;
            end else if (ew_sensor && (r_state != ST_EW_G)) begin
                r_ew_req <= 1'b1;
            end
        end
    end

    assign ns_green  = r_ns.g;
    assign ns_yellow = r_ns.y;
    assign ns_red    = r_ns.r;
    assign ew_green  = r_ew.g;
    assign ew_yellow = r_ew.y;
    assign ew_red    = r_ew.r;
    assign flashing  = r_flashing;

endmodule

`default_nettype wire
